// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// The optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sa_state_t;

    function automatic int cnt_w(int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit combinational full adder; the only arithmetic in the serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, one bit per clock LSB first, start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b - cin, cout=1 means no borrow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] b_ld;
    logic             c_ld;

    // Subtraction is a + ~b + ~cin, so only the loaded values differ.
    always_comb begin
        b_ld = b;
        c_ld = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_ld = ~b;
            c_ld = ~cin;
        end
`endif
    end

    full_adder_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == IDLE && start) begin
            a_sr  <= a;
            b_sr  <= b_ld;
            carry <= c_ld;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            sum_r <= {fa_s, sum_r[WIDTH-1:1]};
            carry <= fa_co;
            // Hold at LAST so a power-of-two WIDTH never wraps the counter.
            if (cnt != LAST) cnt <= cnt + 1'b1;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign sum  = sum_r;
    assign cout = carry;

endmodule
